// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution, branch target,
// iterative shift-add multiplier and the EX/MEM pipeline register.
//
// Ports:
//   clk, rst (async, active-low)
//   ID/EX in : ValidE, FlushE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE,
//              BranchE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE,
//              PCPlus4E
//   Forwarding: ForwardAE, ForwardBE, ResultW (ALUResultM is fed back)
//   To fetch/hazard: PCSrcE, PCTargetE, StallE
//   EX/MEM out: ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M,
//               ALUResultM, WriteDataM, PCPlus4M
module execute_cycle #(
    parameter int MUL_BITS   = 4,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidE,
    input  logic        FlushE,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        StallE,
    output logic        ValidM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    localparam int         N    = 32 / MUL_BITS;
    localparam logic [5:0] LAST = 6'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        stall;

    logic [31:0] src_a, fwd_b, src_b;
    logic [31:0] alu_res, ex_res, partial;
    logic        zero, mul_op, mul_start;

    logic        valid_q, regw_q, memw_q, rsrc_q;
    logic [4:0]  rd_q;
    logic [31:0] res_q, wdata_q, pc4_q;

    function automatic logic [31:0] fwd(
        input logic [31:0] rd,
        input logic [1:0]  sel,
        input logic [31:0] w,
        input logic [31:0] m
    );
        logic [31:0] v;
        case (sel)
            2'b01:   v = w;
            2'b10:   v = m;
            default: v = rd;
        endcase
        return v;
    endfunction

    assign src_a = fwd(RD1_E, ForwardAE, ResultW, res_q);
    assign fwd_b = fwd(RD2_E, ForwardBE, ResultW, res_q);
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    // Opcode 111 yields 0 here; the product is delivered by the FSM in DONE.
    always_comb begin
        alu_res = '0;
        unique case (ALUControlE)
            3'b000:  alu_res = src_a + src_b;
            3'b001:  alu_res = src_a - src_b;
            3'b010:  alu_res = src_a & src_b;
            3'b011:  alu_res = src_a | src_b;
            3'b100:  alu_res = src_a ^ src_b;
            3'b101:  alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
            default: alu_res = '0;
        endcase
    end

    assign mul_op    = (ALUControlE == 3'b111);
    assign zero      = (alu_res == 32'd0);
    assign PCSrcE    = ValidE & BranchE & zero & ~FlushE & ~mul_op;
    assign PCTargetE = PCE + Imm_Ext_E;
    assign mul_start = ENABLE_MUL && ValidE && mul_op && !FlushE;

    // Shift-add partial product for the low MUL_BITS multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    state_d  = S_BUSY;
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    stall    = 1'b1;
                end
            end
            S_BUSY: begin
                stall    = 1'b1;
                prod_d   = prod_q + partial;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A kill aborts any multiply and releases the front end at once.
        if (FlushE || !ENABLE_MUL) begin
            state_d = S_IDLE;
            stall   = 1'b0;
        end
    end

    assign StallE = stall & rst;
    assign ex_res = (state_q == S_DONE) ? prod_q : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            regw_q  <= 1'b0;
            memw_q  <= 1'b0;
            rsrc_q  <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            wdata_q <= '0;
            pc4_q   <= '0;
        end else if (FlushE || stall) begin
            valid_q <= 1'b0;
            regw_q  <= 1'b0;
            memw_q  <= 1'b0;
            rsrc_q  <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            wdata_q <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= ValidE;
            regw_q  <= RegWriteE & ValidE;
            memw_q  <= MemWriteE & ValidE;
            rsrc_q  <= ResultSrcE;
            rd_q    <= RD_E;
            res_q   <= ex_res;
            wdata_q <= fwd_b;
            pc4_q   <= PCPlus4E;
        end
    end

    assign ValidM     = valid_q;
    assign RegWriteM  = regw_q;
    assign MemWriteM  = memw_q;
    assign ResultSrcM = rsrc_q;
    assign RD_M       = rd_q;
    assign ALUResultM = res_q;
    assign WriteDataM = wdata_q;
    assign PCPlus4M   = pc4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed steps plus randomized
// ALU and multiply traffic against a plain-arithmetic reference model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidE, FlushE, RegWriteE, ALUSrcE, MemWriteE;
    logic        ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;

    logic        PCSrcE, StallE, ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    logic        nm_PCSrcE, nm_StallE, nm_ValidM, nm_RegWriteM;
    logic        nm_MemWriteM, nm_ResultSrcM;
    logic [31:0] nm_PCTargetE, nm_ALUResultM, nm_WriteDataM, nm_PCPlus4M;
    logic [4:0]  nm_RD_M;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    execute_cycle #(.MUL_BITS(4), .ENABLE_MUL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    execute_cycle #(.MUL_BITS(4), .ENABLE_MUL(1'b0)) u_nm (
        .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(nm_PCSrcE), .PCTargetE(nm_PCTargetE), .StallE(nm_StallE),
        .ValidM(nm_ValidM), .RegWriteM(nm_RegWriteM),
        .MemWriteM(nm_MemWriteM), .ResultSrcM(nm_ResultSrcM),
        .RD_M(nm_RD_M), .ALUResultM(nm_ALUResultM),
        .WriteDataM(nm_WriteDataM), .PCPlus4M(nm_PCPlus4M)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] rd,
                                         input logic [31:0] w,
                                         input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rd;
    endfunction

    // Multiply in flight: counts stall cycles, checks bubbles, then the result.
    task automatic run_mul(input string tag, input logic [31:0] expv,
                           input bit scramble, input bit chk_nm);
        int stalls = 0;
        while (StallE === 1'b1 && stalls < 20) begin
            stalls++;
            if (chk_nm) chk1({tag, "_nm_stall"}, nm_StallE, 1'b0);
            step();
            chk1({tag, "_bubble"}, ValidM, 1'b0);
            if (chk_nm && stalls == 1) begin
                chk({tag, "_nm_res"}, nm_ALUResultM, 32'd0);
                chk1({tag, "_nm_valid"}, nm_ValidM, 1'b1);
            end
            if (scramble) begin
                RD1_E   = $urandom;
                RD2_E   = $urandom;
                ResultW = $urandom;
                #1;
            end
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'd9);
        step();
        chk({tag, "_res"}, ALUResultM, expv);
        chk1({tag, "_valid"}, ValidM, 1'b1);
        chk1({tag, "_regw"}, RegWriteM, 1'b1);
        ValidE = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_alum, a, b, fb, r;
        logic [1:0]  fa_s, fb_s;
        logic [1:0]  mfw [3];
        logic        v, fl, rw, mw, br, as;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc4;

        mfw[0] = 2'b00; mfw[1] = 2'b01; mfw[2] = 2'b11;

        rst = 1'b0;
        ValidE = 1'b1; FlushE = 1'b0; RegWriteE = 1'b1; ALUSrcE = 1'b0;
        MemWriteE = 1'b0; ResultSrcE = 1'b0; BranchE = 1'b0;
        ALUControlE = 3'b111; RD1_E = 32'd3; RD2_E = 32'd4;
        Imm_Ext_E = '0; RD_E = 5'd1; PCE = '0; PCPlus4E = 32'd4;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;

        step();
        step();
        chk1("rst_stall", StallE, 1'b0);
        chk1("rst_validm", ValidM, 1'b0);
        chk1("rst_regw", RegWriteM, 1'b0);
        chk("rst_alum", ALUResultM, 32'd0);
        chk("rst_pc4", PCPlus4M, 32'd0);
        ValidE = 1'b0;
        rst = 1'b1;
        step();

        // add
        ValidE = 1'b1; ALUControlE = 3'b000; RD1_E = 32'd5; RD2_E = 32'd7;
        RD_E = 5'd3; PCPlus4E = 32'h104;
        step();
        chk("add_res", ALUResultM, 32'd12);
        chk1("add_regw", RegWriteM, 1'b1);
        chk("add_rd", RD_M, 32'd3);
        chk("add_pc4", PCPlus4M, 32'h104);

        // forwarding: seed ALUResultM with 0x20 then sub
        RD1_E = 32'h10; RD2_E = 32'h10;
        step();
        ForwardAE = 2'b01; ResultW = 32'h100; ForwardBE = 2'b10;
        ALUControlE = 3'b001; RD1_E = 32'hDEAD; RD2_E = 32'hBEEF;
        step();
        chk("fwd_sub", ALUResultM, 32'hE0);
        chk("fwd_wdata", WriteDataM, 32'h20);

        // beq taken, then killed
        ForwardAE = 2'b00; ForwardBE = 2'b00; BranchE = 1'b1;
        RegWriteE = 1'b0; RD1_E = 32'd9; RD2_E = 32'd9;
        PCE = 32'h40; Imm_Ext_E = 32'hFFFF_FFF8;
        #1;
        chk1("beq_pcsrc", PCSrcE, 1'b1);
        chk("beq_target", PCTargetE, 32'h38);
        step();
        chk1("beq_validm", ValidM, 1'b1);
        FlushE = 1'b1;
        #1;
        chk1("beqfl_pcsrc", PCSrcE, 1'b0);
        step();
        chk1("beqfl_validm", ValidM, 1'b0);
        FlushE = 1'b0; BranchE = 1'b0;
        exp_alum = 32'd0;

        // randomized ALU traffic
        for (int i = 0; i < 40; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            rw = 1'($urandom); mw = 1'($urandom);
            br = 1'($urandom); as = 1'($urandom);
            op = 3'($urandom_range(0, 6));
            fa_s = 2'($urandom); fb_s = 2'($urandom);
            rd = 5'($urandom); pc4 = $urandom;
            ValidE = v; FlushE = fl; RegWriteE = rw; MemWriteE = mw;
            BranchE = br; ALUSrcE = as; ALUControlE = op;
            ForwardAE = fa_s; ForwardBE = fb_s; RD_E = rd; PCPlus4E = pc4;
            RD1_E = $urandom; RD2_E = $urandom;
            if ($urandom_range(0, 2) == 0) RD2_E = RD1_E;
            Imm_Ext_E = $urandom; PCE = $urandom; ResultW = $urandom;
            a  = pick(fa_s, RD1_E, ResultW, exp_alum);
            fb = pick(fb_s, RD2_E, ResultW, exp_alum);
            b  = as ? Imm_Ext_E : fb;
            r  = alu_ref(op, a, b);
            #1;
            chk1("rnd_pcsrc", PCSrcE, v & br & (r == 32'd0) & ~fl);
            chk("rnd_target", PCTargetE, PCE + Imm_Ext_E);
            chk1("rnd_stall", StallE, 1'b0);
            step();
            if (fl) begin
                chk1("rnd_fl_valid", ValidM, 1'b0);
                chk("rnd_fl_res", ALUResultM, 32'd0);
                chk1("rnd_fl_regw", RegWriteM, 1'b0);
                exp_alum = 32'd0;
            end else begin
                chk("rnd_res", ALUResultM, r);
                chk("rnd_wdata", WriteDataM, fb);
                chk1("rnd_valid", ValidM, v);
                chk1("rnd_regw", RegWriteM, v & rw);
                chk1("rnd_memw", MemWriteM, v & mw);
                chk("rnd_rd", RD_M, 32'(rd));
                chk("rnd_pc4", PCPlus4M, pc4);
                exp_alum = r;
            end
        end

        // multiplies
        FlushE = 1'b0; BranchE = 1'b0; MemWriteE = 1'b0; RegWriteE = 1'b1;
        ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        ValidE = 1'b1; ALUControlE = 3'b111; RD1_E = 32'd7; RD2_E = 32'd6;
        #1;
        chk1("mul_pcsrc", PCSrcE, 1'b0);
        run_mul("mul7x6", 32'd42, 1'b0, 1'b1);

        ValidE = 1'b1; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'hFFFF_FFFF;
        #1;
        run_mul("mulFF", 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ValidE = 1'b1; ALUControlE = 3'b111;
            fa_s = mfw[$urandom_range(0, 2)];
            fb_s = mfw[$urandom_range(0, 2)];
            as = 1'($urandom);
            ForwardAE = fa_s; ForwardBE = fb_s; ALUSrcE = as;
            RD1_E = $urandom; RD2_E = $urandom; ResultW = $urandom;
            Imm_Ext_E = $urandom;
            a = (fa_s == 2'b01) ? ResultW : RD1_E;
            b = as ? Imm_Ext_E : ((fb_s == 2'b01) ? ResultW : RD2_E);
            #1;
            run_mul("mulrnd", a * b, 1'b1, 1'b0);
        end

        // kill on BUSY cycle 3
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0;
        ValidE = 1'b1; ALUControlE = 3'b111; RD1_E = 32'd3; RD2_E = 32'd5;
        #1;
        chk1("kill_start", StallE, 1'b1);
        step();
        step();
        step();
        FlushE = 1'b1;
        step();
        FlushE = 1'b0; ValidE = 1'b0;
        #1;
        chk1("kill_stall", StallE, 1'b0);
        chk1("kill_valid", ValidM, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk1("kill_regw", RegWriteM, 1'b0);
            chk1("kill_stall_n", StallE, 1'b0);
        end

        // async reset mid-multiply
        ValidE = 1'b1; ALUControlE = 3'b111; RD1_E = 32'd11; RD2_E = 32'd13;
        step();
        step();
        rst = 1'b0;
        #1;
        chk1("arst_stall", StallE, 1'b0);
        chk1("arst_valid", ValidM, 1'b0);
        chk1("arst_regw", RegWriteM, 1'b0);
        chk("arst_res", ALUResultM, 32'd0);
        chk("arst_rd", RD_M, 32'd0);
        ValidE = 1'b0;
        rst = 1'b1;
        step();
        chk1("arst_idle", StallE, 1'b0);
        ValidE = 1'b1; ALUControlE = 3'b000; RD1_E = 32'd20; RD2_E = 32'd22;
        step();
        chk("arst_add", ALUResultM, 32'd42);
        chk1("arst_addv", ValidM, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
